// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: ain - bin - bin_in, one bit per clock, LSB first,
// with a start/ready/done handshake and a single borrow flip-flop.
module serial_subtractor_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic             bin_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diffout,
   output logic             borrowout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      d        = a_sr[0] ^ b_sr[0] ^ br;
      br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_next = {d, res[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         diffout   <= '0;
         borrowout <= 1'b0;
         overflow  <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         res       <= '0;
         br        <= 1'b0;
         cnt       <= '0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= ain;
                  b_sr  <= bin;
                  br    <= bin_in;
                  cnt   <= '0;
                  a_msb <= ain[WIDTH-1];
                  b_msb <= bin[WIDTH-1];
                  state <= S_RUN;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               res  <= res_next;
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               // Last bit: publish results straight from the combinational next values.
               if (cnt == CW'(WIDTH-1)) begin
                  cnt       <= '0;
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  diffout   <= res_next;
                  borrowout <= br_next;
                  overflow  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: directed cases, handshake
// timing, abort on reset, back-to-back accepts and random ops vs. arithmetic model.
module tb_serial_subtractor_4bit;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] ain;
   logic [W-1:0] bin;
   logic         bin_in;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diffout;
   logic         borrowout;
   logic         overflow;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int prev_done_cyc = -1;

   logic [W-1:0] exp_d = '0;
   logic         exp_b = 1'b0;
   logic         exp_o = 1'b0;

   serial_subtractor_4bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ain       (ain),
      .bin       (bin),
      .bin_in    (bin_in),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .diffout   (diffout),
      .borrowout (borrowout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // One operation: accept, W busy cycles, one done cycle, back to idle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit hold, input int pulse_at);
      int           full;
      logic [W-1:0] md;
      logic         mb;
      logic         mo;
      full = int'(a) - int'(b) - int'(bi);
      md   = full[W-1:0];
      mb   = (full < 0);
      mo   = (a[W-1] != b[W-1]) && (md[W-1] != a[W-1]);

      nvec++;
      if (ready !== 1'b1) begin
         nerr++; $display("FAIL accept_ready: got %b exp 1", ready);
      end
      ain = a; bin = b; bin_in = bi; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      ain = W'($urandom); bin = W'($urandom); bin_in = 1'($urandom);

      for (int i = 0; i < W; i++) begin
         nvec++;
         if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
            nerr++; $display("FAIL run_flags[%0d]: got busy=%b ready=%b done=%b exp 1 0 0", i, busy, ready, done);
         end
         nvec++;
         if (diffout !== exp_d || borrowout !== exp_b || overflow !== exp_o) begin
            nerr++; $display("FAIL run_hold[%0d]: got %h/%b/%b exp %h/%b/%b", i, diffout, borrowout, overflow, exp_d, exp_b, exp_o);
         end
         if (i == pulse_at) begin
            start = 1'b1; ain = '1; bin = '1; bin_in = 1'b1;
         end else if (!hold) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end

      nvec++;
      if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
         nerr++; $display("FAIL done_flags: got done=%b busy=%b ready=%b exp 1 0 0", done, busy, ready);
      end
      nvec++;
      if (diffout !== md || borrowout !== mb || overflow !== mo) begin
         nerr++; $display("FAIL result a=%h b=%h bi=%b: got %h/%b/%b exp %h/%b/%b", a, b, bi, diffout, borrowout, overflow, md, mb, mo);
      end
      if (hold && prev_done_cyc >= 0) begin
         nvec++;
         if (cyc - prev_done_cyc !== W + 2) begin
            nerr++; $display("FAIL done_spacing: got %0d exp %0d", cyc - prev_done_cyc, W + 2);
         end
      end
      prev_done_cyc = cyc;
      exp_d = md; exp_b = mb; exp_o = mo;

      @(posedge clk); #1;
      nvec++;
      if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         nerr++; $display("FAIL idle_flags: got ready=%b done=%b busy=%b exp 1 0 0", ready, done, busy);
      end
      nvec++;
      if (diffout !== exp_d || borrowout !== exp_b || overflow !== exp_o) begin
         nerr++; $display("FAIL idle_hold: got %h/%b/%b exp %h/%b/%b", diffout, borrowout, overflow, exp_d, exp_b, exp_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ain = '0; bin = '0; bin_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         nerr++; $display("FAIL reset_flags: got ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done);
      end
      nvec++;
      if (diffout !== '0 || borrowout !== 1'b0 || overflow !== 1'b0) begin
         nerr++; $display("FAIL reset_outs: got %h/%b/%b exp 0/0/0", diffout, borrowout, overflow);
      end
      rst = 1'b0;
      exp_d = '0; exp_b = 1'b0; exp_o = 1'b0;
   endtask

   task automatic test_directed();
      do_op(4'h9, 4'h3, 1'b0, 1'b0, -1);
      do_op(4'h3, 4'h9, 1'b0, 1'b0, -1);
      do_op(4'h0, 4'h0, 1'b1, 1'b0, -1);
      do_op(4'h8, 4'h1, 1'b0, 1'b0, -1);
      do_op(4'h7, 4'hF, 1'b0, 1'b0, -1);
      do_op(4'hF, 4'hF, 1'b1, 1'b0, -1);
      do_op(4'h0, 4'hF, 1'b1, 1'b0, -1);
   endtask

   task automatic test_ignore_start();
      do_op(4'h5, 4'h2, 1'b0, 1'b0, 1);
   endtask

   task automatic test_abort();
      bit saw_done;
      ain = 4'h6; bin = 4'h1; bin_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_d = '0; exp_b = 1'b0; exp_o = 1'b0;
      nvec++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         nerr++; $display("FAIL abort_flags: got ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done);
      end
      nvec++;
      if (diffout !== '0 || borrowout !== 1'b0 || overflow !== 1'b0) begin
         nerr++; $display("FAIL abort_outs: got %h/%b/%b exp 0/0/0", diffout, borrowout, overflow);
      end
      saw_done = 1'b0;
      repeat (W + 2) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      nvec++;
      if (saw_done !== 1'b0) begin
         nerr++; $display("FAIL abort_no_done: got done pulse exp none");
      end
   endtask

   task automatic test_back_to_back();
      prev_done_cyc = -1;
      for (int k = 0; k < 4; k++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, -1);
      start = 1'b0;
      prev_done_cyc = -1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 1000; k++)
         do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
